// File: rtl/pixel_sensor_controller_pkg.sv
// Shared configuration defaults and FSM state encoding for the pixel sensor frame sequencer.
package pixel_sensor_controller_pkg;

    localparam int DEF_PIXEL_BITS         = 8;
    localparam int DEF_PIXEL_ARRAY_HEIGHT = 2;
    localparam int DEF_ERASE_CYCLES       = 5;
    localparam int DEF_CNT_BITS           = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4,
        ST_DONE    = 3'd5
    } pixel_ctrl_state_t;

    // Row index width; a single-row array still gets a 1-bit index.
    function automatic int row_bits(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

endpackage

// File: rtl/pixel_sensor_controller_if.sv
// Row readout bundle between the frame sequencer and the downstream readout.
interface pixel_sensor_controller_if
    import pixel_sensor_controller_pkg::*;
#(
    parameter int HEIGHT   = DEF_PIXEL_ARRAY_HEIGHT,
    parameter int ROW_BITS = row_bits(HEIGHT)
) ();

    // Handshake: the row on read_row/row_index is transferred on any cycle where
    // row_valid && row_ready; row_valid, read_row and row_index hold while row_ready is low,
    // and row_ready is ignored while row_valid is low.
    logic [HEIGHT-1:0]   read_row;
    logic                row_valid;
    logic                row_ready;
    logic [ROW_BITS-1:0] row_index;

    modport master (
        output read_row,
        output row_valid,
        output row_index,
        input  row_ready
    );

    modport slave (
        input  read_row,
        input  row_valid,
        input  row_index,
        output row_ready
    );

endinterface

// File: rtl/pixel_sensor_controller_row_seq.sv
// READ-phase row walker: one-hot row select, one settle cycle, then valid/ready per row.
module pixel_row_sequencer
    import pixel_sensor_controller_pkg::*;
#(
    parameter int HEIGHT   = DEF_PIXEL_ARRAY_HEIGHT,
    parameter int ROW_BITS = row_bits(HEIGHT)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                begin_read,
    input  logic                row_ready,
    output logic [HEIGHT-1:0]   read_row,
    output logic                row_valid,
    output logic [ROW_BITS-1:0] row_index,
    output logic                last_row_done
);

    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(HEIGHT - 1);

    logic [HEIGHT-1:0]   read_row_q, read_row_d;
    logic                row_valid_q, row_valid_d;
    logic [ROW_BITS-1:0] row_index_q, row_index_d;
    logic                handshake;

    always_comb begin
        read_row_d    = read_row_q;
        row_valid_d   = row_valid_q;
        row_index_d   = row_index_q;
        last_row_done = 1'b0;
        handshake     = row_valid_q & row_ready;
        if (begin_read) begin
            read_row_d  = HEIGHT'(1);
            row_valid_d = 1'b0;
            row_index_d = '0;
        end else if (handshake) begin
            row_valid_d = 1'b0;
            if (row_index_q == LAST_ROW) begin
                read_row_d    = '0;
                row_index_d   = '0;
                last_row_done = 1'b1;
            end else begin
                row_index_d = row_index_q + ROW_BITS'(1);
                read_row_d  = HEIGHT'(1) << row_index_d;
            end
        end else if (|read_row_q) begin
            // The row's tristate DATA bus needs one cycle to settle after READ moves.
            row_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_row_q  <= '0;
            row_valid_q <= 1'b0;
            row_index_q <= '0;
        end else begin
            read_row_q  <= read_row_d;
            row_valid_q <= row_valid_d;
            row_index_q <= row_index_d;
        end
    end

    assign read_row  = read_row_q;
    assign row_valid = row_valid_q;
    assign row_index = row_index_q;

endmodule

// File: rtl/pixel_sensor_controller.sv
// Frame sequencer: drives ERASE/EXPOSE/ramp lines for a frame, then hands rows to the readout.
module pixel_sensor_controller
    import pixel_sensor_controller_pkg::*;
#(
    parameter int PIXEL_BITS         = DEF_PIXEL_BITS,
    parameter int PIXEL_ARRAY_HEIGHT = DEF_PIXEL_ARRAY_HEIGHT,
    parameter int ERASE_CYCLES       = DEF_ERASE_CYCLES,
    parameter int CNT_BITS           = DEF_CNT_BITS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [CNT_BITS-1:0]       expose_cycles,
    output logic                      erase,
    output logic                      expose,
    output logic                      analog_ramp,
    output logic [PIXEL_BITS-1:0]     digital_ramp,
    output logic                      busy,
    output logic                      frame_done,
    output pixel_ctrl_state_t         state_dbg,
    pixel_sensor_controller_if.master row_if
);

    localparam logic [PIXEL_BITS-1:0] RAMP_MAX   = '1;
    localparam logic [CNT_BITS-1:0]   ERASE_LAST = CNT_BITS'(ERASE_CYCLES - 1);

    pixel_ctrl_state_t     state_q, state_d;
    logic [CNT_BITS-1:0]   timer_q, timer_d;
    logic [CNT_BITS-1:0]   expose_len_q, expose_len_d;
    logic [PIXEL_BITS-1:0] ramp_q, ramp_d;
    logic                  erase_q, erase_d;
    logic                  expose_q, expose_d;
    logic                  analog_ramp_q, analog_ramp_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  begin_read;
    logic                  last_row_done;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        expose_len_d = expose_len_q;
        ramp_d       = '0;
        begin_read   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A zero exposure request still exposes for one cycle.
                    expose_len_d = (expose_cycles == '0) ? CNT_BITS'(1) : expose_cycles;
                    timer_d      = '0;
                    state_d      = ST_ERASE;
                end
            end
            ST_ERASE: begin
                if (timer_q == ERASE_LAST) begin
                    timer_d = '0;
                    state_d = ST_EXPOSE;
                end else begin
                    timer_d = timer_q + CNT_BITS'(1);
                end
            end
            ST_EXPOSE: begin
                if (timer_q == expose_len_q - CNT_BITS'(1)) begin
                    timer_d = '0;
                    state_d = ST_CONVERT;
                end else begin
                    timer_d = timer_q + CNT_BITS'(1);
                end
            end
            ST_CONVERT: begin
                if (ramp_q == RAMP_MAX) begin
                    state_d    = ST_READ;
                    begin_read = 1'b1;
                end else begin
                    ramp_d = ramp_q + PIXEL_BITS'(1);
                end
            end
            ST_READ: begin
                if (last_row_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line outputs are registered from the next state so they align with state_q.
        erase_d       = (state_d == ST_ERASE);
        expose_d      = (state_d == ST_EXPOSE);
        analog_ramp_d = (state_d == ST_CONVERT);
        busy_d        = (state_d != ST_IDLE);
        frame_done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            expose_len_q  <= '0;
            ramp_q        <= '0;
            erase_q       <= 1'b0;
            expose_q      <= 1'b0;
            analog_ramp_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            expose_len_q  <= expose_len_d;
            ramp_q        <= ramp_d;
            erase_q       <= erase_d;
            expose_q      <= expose_d;
            analog_ramp_q <= analog_ramp_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    pixel_row_sequencer #(
        .HEIGHT   (PIXEL_ARRAY_HEIGHT),
        .ROW_BITS (row_bits(PIXEL_ARRAY_HEIGHT))
    ) u_row_seq (
        .clk           (clk),
        .reset_n       (reset_n),
        .begin_read    (begin_read),
        .row_ready     (row_if.row_ready),
        .read_row      (row_if.read_row),
        .row_valid     (row_if.row_valid),
        .row_index     (row_if.row_index),
        .last_row_done (last_row_done)
    );

    assign erase        = erase_q;
    assign expose       = expose_q;
    assign analog_ramp  = analog_ramp_q;
    assign digital_ramp = ramp_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pixel_sensor_controller.sv
// Scoreboard bench for pixel_sensor_controller: frame events predicted from the frame rules,
// compared by a negedge monitor as the DUT produces them.
module tb_pixel_sensor_controller;
    import pixel_sensor_controller_pkg::*;

    localparam int PB       = DEF_PIXEL_BITS;
    localparam int H        = DEF_PIXEL_ARRAY_HEIGHT;
    localparam int EC       = DEF_ERASE_CYCLES;
    localparam int CB       = DEF_CNT_BITS;
    localparam int RB       = row_bits(H);
    localparam int RAMP_LEN = 1 << PB;

    localparam int K_ERASE  = 1;
    localparam int K_EXPOSE = 2;
    localparam int K_RAMP   = 3;
    localparam int K_ROW    = 4;
    localparam int K_FRAME  = 5;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [CB-1:0]     expose_cycles = '0;
    logic              erase, expose, analog_ramp, busy, frame_done;
    logic [PB-1:0]     digital_ramp;
    pixel_ctrl_state_t state_dbg;

    int   ready_mode = 0;
    logic ready_manual = 1'b1;
    logic rnd_ready = 1'b1;

    pixel_sensor_controller_if #(.HEIGHT(H), .ROW_BITS(RB)) row_if ();

    assign row_if.row_ready = (ready_mode == 1) ? rnd_ready : ready_manual;

    pixel_sensor_controller #(
        .PIXEL_BITS         (PB),
        .PIXEL_ARRAY_HEIGHT (H),
        .ERASE_CYCLES       (EC),
        .CNT_BITS           (CB)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .expose_cycles (expose_cycles),
        .erase         (erase),
        .expose        (expose),
        .analog_ramp   (analog_ramp),
        .digital_ramp  (digital_ramp),
        .busy          (busy),
        .frame_done    (frame_done),
        .state_dbg     (state_dbg),
        .row_if        (row_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] ev(input int kind, input int val);
        return {4'(kind), 28'(val)};
    endfunction

    function automatic string kind_name(input logic [31:0] e);
        case (int'(e[31:28]))
            K_ERASE:  return "erase_width";
            K_EXPOSE: return "expose_width";
            K_RAMP:   return "ramp_width";
            K_ROW:    return "row_handshake";
            K_FRAME:  return "frame_length";
            default:  return "unknown_event";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic got_event(input int kind, input int val);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got 0x%0h expected no event at %0t", ev(kind, val), $time);
        end else begin
            e = exp_q.pop_front();
            check(kind_name(e), ev(kind, val), e);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({erase, expose, analog_ramp, digital_ramp, busy, frame_done,
                    row_if.read_row, row_if.row_valid, row_if.row_index});
    endfunction

    // Reference model: what one accepted frame must look like, from the frame rules alone.
    task automatic push_frame(input int e);
        int e_eff;
        e_eff = (e == 0) ? 1 : e;
        exp_q.push_back(ev(K_ERASE, EC));
        exp_q.push_back(ev(K_EXPOSE, e_eff));
        exp_q.push_back(ev(K_RAMP, RAMP_LEN));
        for (int r = 0; r < H; r++) begin
            exp_q.push_back(ev(K_ROW, ((1 << r) << RB) | r));
        end
        exp_q.push_back(ev(K_FRAME, EC + e_eff + RAMP_LEN + 2 * H + 1));
    endtask

    // ---------------- monitor ----------------
    int   erase_w = 0, expose_w = 0, ramp_w = 0, busy_w = 0, stall_w = 0;
    logic frame_done_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            erase_w = 0; expose_w = 0; ramp_w = 0; busy_w = 0; stall_w = 0;
            frame_done_prev = 1'b0;
        end else begin
            check("mutex", 32'($countones({erase, expose, analog_ramp, |row_if.read_row}) <= 1), 32'd1);
            check("read_row_onehot0", 32'($onehot0(row_if.read_row)), 32'd1);
            if (frame_done) check("frame_done_width", 32'(frame_done_prev), 32'd0);

            if (analog_ramp) begin
                check("ramp_value", 32'(digital_ramp), 32'(ramp_w));
                ramp_w++;
            end else begin
                check("ramp_idle", 32'(digital_ramp), 32'd0);
                if (ramp_w != 0) begin got_event(K_RAMP, ramp_w); ramp_w = 0; end
            end
            if (erase) erase_w++;
            else if (erase_w != 0) begin got_event(K_ERASE, erase_w); erase_w = 0; end
            if (expose) expose_w++;
            else if (expose_w != 0) begin got_event(K_EXPOSE, expose_w); expose_w = 0; end

            if (busy) busy_w++;
            if (row_if.row_valid && !row_if.row_ready) stall_w++;
            if (row_if.row_valid && row_if.row_ready)
                got_event(K_ROW, int'({row_if.read_row, row_if.row_index}));
            if (frame_done) begin
                got_event(K_FRAME, busy_w - stall_w);
                busy_w = 0;
                stall_w = 0;
            end
            frame_done_prev = frame_done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_frame(input int e);
        push_frame(e);
        @(posedge clk); #1;
        expose_cycles = CB'(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit poke_start);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: frame_done not seen within 5000 cycles at %0t", $time);
        end
        if (poke_start) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic wait_for(input int what, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            case (what)
                0: ok = row_if.row_valid;
                1: ok = analog_ramp;
                default: ok = analog_ramp && (digital_ramp == PB'(100));
            endcase
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: condition %0d not reached within %0d cycles", what, budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int e;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs_vec(), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        reset_n = 1'b1;

        // Nominal frame, ready tied high
        start_frame(10);
        wait_done(1'b0);
        repeat (3) @(negedge clk);
        check("idle_outputs", outs_vec(), 32'd0);
        check("idle_state", 32'(state_dbg), 32'(ST_IDLE));

        // Backpressure on row 0
        @(posedge clk); #1;
        ready_manual = 1'b0;
        start_frame(3);
        wait_for(0, 2000, ok);
        if (ok) begin
            for (int i = 0; i < 20; i++) begin
                if (i > 0) @(negedge clk);
                check("stall_hold", 32'({row_if.read_row, row_if.row_valid, row_if.row_index}),
                      32'({H'(1), 1'b1, RB'(0)}));
            end
            @(posedge clk); #1;
            ready_manual = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("stall_release", 32'({row_if.read_row, row_if.row_valid, row_if.row_index}),
                  32'({H'(2), 1'b0, RB'(1)}));
        end
        wait_done(1'b0);

        // Zero exposure, and mid-frame changes of expose_cycles
        start_frame(0);
        repeat (3) @(posedge clk);
        #1 expose_cycles = CB'(200);
        wait_done(1'b0);
        start_frame(7);
        repeat (8) @(posedge clk);
        #1 expose_cycles = CB'(1);
        wait_done(1'b0);

        // Start while busy: during CONVERT and on the frame_done cycle
        start_frame(4);
        wait_for(1, 2000, ok);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(1'b1);
        repeat (5) @(negedge clk);
        check("ignored_start_busy", 32'(busy), 32'd0);
        check("ignored_start_state", 32'(state_dbg), 32'(ST_IDLE));

        // Asynchronous reset mid-conversion
        start_frame(20);
        wait_for(2, 2000, ok);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", outs_vec(), 32'd0);
        check("async_reset_state", 32'(state_dbg), 32'(ST_IDLE));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_idle", outs_vec(), 32'd0);
        start_frame(12);
        wait_done(1'b0);

        // Randomized frames with random consumer backpressure
        @(posedge clk); #1 ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            e = $urandom_range(0, 40);
            start_frame(e);
            repeat ($urandom_range(1, 8)) @(posedge clk);
            #1 expose_cycles = CB'($urandom_range(0, 60));
            wait_done(1'b0);
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within 1000000 time units");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
